serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one full-adder cell plus a registered carry.
- Consumes operands and produces one sum bit per clock, LSB first, using the team's full-adder equations:
  - s = a^b^c
  - cout = ab | ac | bc
- Sits downstream of operand registers and upstream of any result consumer. A start/busy/done handshake sequences it.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 2 or more.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
- sum  output  WIDTH  result register; holds the last completed result.
- cout  output  1  final carry-out; holds the last completed value.

Behaviour:
- Reset: rst=1 at an edge forces the following, regardless of state, including mid-operation:
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Internal shift registers, carry and bit counter = 0.
  - Any in-flight addition is discarded.
- States: IDLE and RUN.
- IDLE:
  - busy = 0.
  - On an edge with start=1: capture a, b into shift registers, set carry = cin, set counter = 0, go to RUN.
- RUN:
  - busy = 1.
  - Each edge computes the full-adder outputs on (a_sr[0], b_sr[0], carry).
  - The sum bit shifts into the MSB of a partial-sum register, which shifts right.
  - a_sr and b_sr shift right; carry updates to the full-adder carry; counter increments.
  - On the edge that processes bit WIDTH-1 (counter = WIDTH-1):
    - Copy the completed partial sum to sum and the final carry to cout.
    - Set done = 1 and go to IDLE.
- Latency:
  - Start accepted at edge 0.
  - Bits 0..WIDTH-1 are processed at edges 1..WIDTH.
  - busy = 1 for exactly WIDTH cycles, after edges 0..WIDTH-1.
  - done = 1 for exactly one cycle, after edge WIDTH; it clears at the next edge unless a new completion occurs.
- Output stability:
  - sum and cout change only on the completion edge or on reset.
  - They hold the previous result during RUN; partial results are never visible.
- start while busy=1: ignored, with no effect on the operation in flight.
- start=1 in the done cycle: the state is IDLE, so the start is accepted. A back-to-back operation begins with no idle gap, and sum/cout keep the just-completed result until the next completion.
- start held high continuously: starts a new addition every WIDTH+1 edges; operands are re-sampled at each acceptance.
- Operand changes after acceptance: no effect until the next acceptance.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH) bits, no wrap beyond WIDTH-1.
- Simultaneous rst and start: rst wins.

Test Plan:
- Reset, then hold idle. Response: busy=0, done=0, sum=0x00, cout=0 for 10 cycles.
- a=0x5A, b=0x3C, cin=0, start pulse. Response: busy high 8 cycles, then done pulse for 1 cycle, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0, then a=0xFF, b=0xFF, cin=1. Responses: sum=0x00, cout=1; then sum=0xFF, cout=1.
- Start pulses during busy with different operands. Response: ignored, result still matches the first operands; done occurs exactly once.
- rst asserted on the 4th RUN cycle. Response: at the next edge busy=0 and sum/cout=0; no done pulse follows.
- start held high, a=0x01, b=0x01, cin=1, then a=0x80, b=0x80, cin=0. Responses:
  - Done pulses 9 edges apart, with the second start accepted in the done cycle.
  - Results: sum=0x03, cout=0; then sum=0x00, cout=1.
  - Random operand sweep is checked against a + b + cin.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell and
// a registered carry. One operand bit pair is consumed per clock, LSB first.
//
// Handshake: start is sampled only in IDLE. The accepting edge captures a, b
// and cin. busy is high for the WIDTH cycles of the addition. done pulses for
// one cycle when the result lands in sum/cout. start is ignored while busy.
//
// Ports:
//   clk   - single clock, rising edge
//   rst   - synchronous active-high reset
//   start - request a new addition (sampled in IDLE only)
//   a, b  - WIDTH-bit operands, captured on the accepting edge
//   cin   - carry-in, captured on the accepting edge
//   busy  - high while an addition is in progress
//   done  - one-cycle completion pulse
//   sum   - last completed sum (holds during RUN)
//   cout  - last completed carry-out (holds during RUN)
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_c;
    logic             last;
    logic             accept;

    // Full-adder cell on the current LSBs and the running carry.
    assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == LAST_BIT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == LAST_BIT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        if (state == RUN) begin
            busy = 1'b1;
        end
    end

    // Datapath: operand shifters, carry, bit counter, partial sum and the
    // result registers. sum/cout are only written on the completion edge so
    // partial results never appear on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
                psum  <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                carry <= fa_c;
                // Sum bits enter at the MSB and walk down, so after WIDTH
                // shifts bit 0 of the result sits at psum[0].
                psum  <= {fa_s, psum[WIDTH-1:1]};
                if (last) begin
                    cnt  <= '0;
                    sum  <= {fa_s, psum[WIDTH-1:1]};
                    cout <= fa_c;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH = 8). Stimulus pushes the expected
// {cout, sum} into exp_q; a monitor pops and compares on every done pulse.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0]   exp_q[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    int           n_done = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("done_without_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                check("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver: present operands with start, return just after the accepting edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W:0] exp);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done (bounded), counting busy cycles; then check done is a single pulse.
    task automatic wait_done(output int bc);
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
            if (busy) bc++;
        end
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
    endtask

    initial begin
        int bc;
        int d0;
        int nd;
        int t0;
        int t1;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        t0    = 0;
        t1    = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state held while idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", 32'({busy, done, cout, sum}), 32'd0);
        end

        // Basic addition with busy-length check
        issue(8'h5A, 8'h3C, 1'b0, 9'h096);
        wait_done(bc);
        check("busy_cycles", 32'(bc), 32'd8);

        // Carry propagation cases
        issue(8'hFF, 8'h01, 1'b0, 9'h100);
        wait_done(bc);
        issue(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        wait_done(bc);
        check("busy_cycles_ff", 32'(bc), 32'd8);

        // start pulses while busy are ignored
        d0 = n_done;
        issue(8'h12, 8'h34, 1'b0, 9'h046);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = (i == 1) || (i == 4);
            a     = 8'hAA;
            b     = 8'h55;
            cin   = 1'b1;
            if (i == 2) check("sum_hold_in_run", 32'({cout, sum}), 32'h1FF);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        repeat (12) @(negedge clk);
        check("single_done_when_busy_start", 32'(n_done - d0), 32'd1);

        // Reset on the 4th RUN cycle discards the operation
        issue(8'h77, 8'h11, 1'b0, 9'h088);
        repeat (4) @(negedge clk);
        check("sum_before_reset", 32'({cout, sum}), 32'h046);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("reset_mid_run", 32'({busy, done, cout, sum}), 32'd0);
        rst = 1'b0;
        d0 = n_done;
        repeat (15) @(negedge clk);
        check("no_done_after_reset", 32'(n_done - d0), 32'd0);

        // start held high: back-to-back operations, accepted in the done cycle
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b1;
        start = 1'b1;
        exp_q.push_back(9'h003);
        nd = 0;
        for (int cyc = 0; cyc < 40 && nd < 2; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                a   = 8'h80;
                b   = 8'h80;
                cin = 1'b0;
                exp_q.push_back(9'h100);
            end
            if (done) begin
                if (nd == 0) t0 = cyc;
                else t1 = cyc;
                nd++;
                if (nd == 2) start = 1'b0;
            end
        end
        check("held_start_done_count", 32'(nd), 32'd2);
        check("done_spacing", 32'(t1 - t0), 32'd9);
        @(negedge clk);
        check("idle_after_held_start", 32'(busy), 32'd0);

        // Operand sweep against a + b + cin
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
            wait_done(bc);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
